// File: rtl/lanes_pkg.sv
// lanes_pkg: shared constants and helpers for the two-lane serializer/deserializer pair
// Contents:
//   DATA_WIDTH              widest parallel word carried by the lanes
//   LEN_GEN2/GEN3/GEN4      word lengths in bits for each link generation
//   gen_speed_e             encoding of the gen_speed selector
//   phase_e                 word phase, implied by the bit index
//   speed_to_len()          maps gen_speed to word length in bits
package lanes_pkg;

    localparam int DATA_WIDTH = 132;

    localparam logic [7:0] LEN_GEN2 = 8'd8;
    localparam logic [7:0] LEN_GEN3 = 8'd132;
    localparam logic [7:0] LEN_GEN4 = 8'd66;

    typedef enum logic [1:0] {
        GS_GEN2   = 2'b00,
        GS_GEN3   = 2'b01,
        GS_GEN4   = 2'b10,
        GS_GEN2_B = 2'b11
    } gen_speed_e;

    typedef enum logic {
        PH_START   = 1'b0,
        PH_COLLECT = 1'b1
    } phase_e;

    // 2'b11 is treated as the 8-bit word length, the same as 2'b00
    function automatic logic [7:0] speed_to_len(input logic [1:0] gs);
        return gs == GS_GEN3 ? LEN_GEN3 : gs == GS_GEN4 ? LEN_GEN4 : LEN_GEN2;
    endfunction

endpackage

// File: rtl/deser_lane.sv
// deser_lane: one lane's assembly register plus its registered output word
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   enable      lane carries valid data this cycle; low discards the partial word
//   bit_idx     shared index of the bit sampled this cycle (0 starts a new word)
//   load        shared strobe: this cycle's bit completes the word
//   bit_in      serial input bit
//   rx_out      last completed word, zero above the word length
module deser_lane #(
    parameter int DATA_WIDTH = 132,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [CNT_W-1:0]      bit_idx,
    input  logic                  load,
    input  logic                  bit_in,
    output logic [DATA_WIDTH-1:0] rx_out
);

    logic [DATA_WIDTH-1:0] asm_q;
    logic [DATA_WIDTH-1:0] asm_nx;

    // Bit 0 starts from a clean register so bits above the word length stay zero
    always_comb begin
        asm_nx          = bit_idx == '0 ? '0 : asm_q;
        asm_nx[bit_idx] = bit_in;
    end

    // The output is loaded from asm_nx so the completed word includes the final bit
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q  <= '0;
            rx_out <= '0;
        end else begin
            asm_q <= enable ? asm_nx : '0;
            if (load)
                rx_out <= asm_nx;
        end
    end

endmodule

// File: rtl/lanes_deserializer.sv
// lanes_deserializer: two-lane LSB-first serial-to-parallel receiver with word strobe
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   enable                    lanes carry valid serial data; high on bit 0 of the first word
//   gen_speed                 word length select, latched at each word start (00/11: 8, 01: 132, 10: 66)
//   Lane_0_rx_in, Lane_1_rx_in  serial inputs, one bit per clock per lane
//   Lane_0_rx_out, Lane_1_rx_out  last completed words
//   rx_valid                  one-cycle strobe when both output words are new
//   descr_rst                 next sampled bit is bit 0 of a word (reseeds the descrambler)
//   word_cnt                  completed-word count, present only with DESER_WORD_CNT_EN
// Optional feature macro: DESER_WORD_CNT_EN
module lanes_deserializer #(
    parameter int DATA_WIDTH = lanes_pkg::DATA_WIDTH,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [1:0]            gen_speed,
    input  logic                  Lane_0_rx_in,
    input  logic                  Lane_1_rx_in,
    output logic [DATA_WIDTH-1:0] Lane_0_rx_out,
    output logic [DATA_WIDTH-1:0] Lane_1_rx_out,
    output logic                  rx_valid,
    output logic                  descr_rst
`ifdef DESER_WORD_CNT_EN
    ,
    output logic [15:0]           word_cnt
`endif
);

    import lanes_pkg::phase_e;
    import lanes_pkg::PH_START;
    import lanes_pkg::PH_COLLECT;
    import lanes_pkg::speed_to_len;

    logic [CNT_W-1:0] bit_idx, bit_idx_nx;
    logic [CNT_W-1:0] word_len, word_len_nx;
    logic             last;
    phase_e           phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx  <= '0;
            word_len <= CNT_W'(lanes_pkg::LEN_GEN2);
            rx_valid <= 1'b0;
        end else begin
            bit_idx  <= bit_idx_nx;
            word_len <= word_len_nx;
            rx_valid <= last;
        end
    end

    // word_len is only consulted in COLLECT, so the value latched at START governs the whole word
    always_comb begin
        phase       = bit_idx == '0 ? PH_START : PH_COLLECT;
        last        = enable && phase == PH_COLLECT && bit_idx == word_len - CNT_W'(1);
        word_len_nx = enable && phase == PH_START ? CNT_W'(speed_to_len(gen_speed)) : word_len;
        bit_idx_nx  = !enable || last ? '0 : bit_idx + CNT_W'(1);
        descr_rst   = phase == PH_START;
    end

`ifdef DESER_WORD_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            word_cnt <= '0;
        else if (last)
            word_cnt <= word_cnt + 16'd1;
    end
`endif

    deser_lane #(.DATA_WIDTH(DATA_WIDTH), .CNT_W(CNT_W)) u_lane0 (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .bit_idx (bit_idx),
        .load    (last),
        .bit_in  (Lane_0_rx_in),
        .rx_out  (Lane_0_rx_out)
    );

    deser_lane #(.DATA_WIDTH(DATA_WIDTH), .CNT_W(CNT_W)) u_lane1 (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .bit_idx (bit_idx),
        .load    (last),
        .bit_in  (Lane_1_rx_in),
        .rx_out  (Lane_1_rx_out)
    );

endmodule

// File: tb/tb_lanes_deserializer.sv
// tb_lanes_deserializer: scoreboard bench for lanes_deserializer with a word-level reference model
module tb_lanes_deserializer;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [1:0]   gen_speed;
    logic         l0_in, l1_in;
    logic [131:0] l0_out, l1_out;
    logic         rx_valid, descr_rst;
`ifdef DESER_WORD_CNT_EN
    logic [15:0]  word_cnt;
`endif

    lanes_deserializer dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .gen_speed     (gen_speed),
        .Lane_0_rx_in  (l0_in),
        .Lane_1_rx_in  (l1_in),
        .Lane_0_rx_out (l0_out),
        .Lane_1_rx_out (l1_out),
        .rx_valid      (rx_valid),
        .descr_rst     (descr_rst)
`ifdef DESER_WORD_CNT_EN
        ,
        .word_cnt      (word_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [131:0] d0;
        logic [131:0] d1;
    } exp_t;

    exp_t         sb[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    bit           mon_on = 1'b0;
    bit           mid = 1'b0;
    logic [131:0] held0 = '0, held1 = '0;
    int           nwords = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int model_len(input logic [1:0] gs);
        return gs == 2'b01 ? 132 : gs == 2'b10 ? 66 : 8;
    endfunction

    function automatic logic [131:0] trunc(input logic [131:0] w, input int len);
        logic [131:0] r;
        r = '0;
        for (int i = 0; i < len; i++) r[i] = w[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [131:0] act, input logic [131:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Serializes n bits of a word; gen_speed is meaningful only on bit 0 and is scrambled afterwards.
    // switch_at >= 0 forces gen_speed to switch_gs from that bit on, to model a mid-word change.
    task automatic send(input logic [1:0] gs, input logic [131:0] w0, input logic [131:0] w1,
                        input int n, input int switch_at, input logic [1:0] switch_gs);
        int len;
        len = model_len(gs);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("descr_rst", {131'd0, descr_rst}, {131'd0, i == 0});
            enable = 1'b1;
            gen_speed = i == 0 ? gs : (switch_at >= 0 && i >= switch_at) ? switch_gs : 2'($urandom_range(0, 3));
            l0_in = w0[i];
            l1_in = w1[i];
            mid = i != len - 1;
            if (i == len - 1) sb.push_back('{cyc + 1, trunc(w0, len), trunc(w1, len)});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("descr_rst_idle", {131'd0, descr_rst}, {131'd0, !mid});
            mid = 1'b0;
            enable = 1'b0;
            gen_speed = 2'($urandom_range(0, 3));
            l0_in = 1'($urandom);
            l1_in = 1'($urandom);
        end
    endtask

    function automatic logic [131:0] rnd132();
        return {4'($urandom), $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: every strobe pops one expected word pair; between strobes the outputs must hold
    always @(negedge clk) begin
        if (mon_on) begin
            if (rx_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rx_valid: got strobe at cycle %0d want none", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("valid_cycle", 132'(cyc), 132'(e.cyc));
                    chk("lane0_word", l0_out, e.d0);
                    chk("lane1_word", l1_out, e.d1);
                    held0 = e.d0;
                    held1 = e.d1;
                    nwords++;
`ifdef DESER_WORD_CNT_EN
                    chk("word_cnt", 132'(word_cnt), 132'(16'(nwords)));
`endif
                end
            end else begin
                chk("lane0_hold", l0_out, held0);
                chk("lane1_hold", l1_out, held1);
            end
        end
    end

    initial begin
        logic [131:0] a0, a1;
        rst = 1'b1;
        enable = 1'b0;
        gen_speed = 2'b00;
        l0_in = 1'b0;
        l1_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_lane0", l0_out, '0);
        chk("reset_lane1", l1_out, '0);
        chk("reset_rx_valid", {131'd0, rx_valid}, '0);
        chk("reset_descr_rst", {131'd0, descr_rst}, 132'd1);
`ifdef DESER_WORD_CNT_EN
        chk("reset_word_cnt", 132'(word_cnt), '0);
`endif
        mon_on = 1'b1;
        idle(2);

        // 8-bit word: lane0 bits 1,0,1,1,0,0,1,0 LSB first, lane1 all ones
        a0 = 132'h4D;
        send(2'b00, a0, 132'hFF, 8, -1, 2'b00);
        idle(3);
        chk("directed_lane0_4d", held0, 132'h4D);

        // three back-to-back 132-bit words
        for (int k = 0; k < 3; k++) send(2'b01, rnd132(), rnd132(), 132, -1, 2'b00);
        idle(2);

        // 66-bit alternating pattern
        a0 = 132'h2_AAAA_AAAA_AAAA_AAAA;
        send(2'b10, a0, ~a0, 66, -1, 2'b00);
        idle(2);

        // aborted 66-bit word after 30 bits, then a full word
        send(2'b10, rnd132(), rnd132(), 30, -1, 2'b00);
        idle(4);
        send(2'b10, rnd132(), rnd132(), 66, -1, 2'b00);

        // gen_speed switches 10->00 at bit 20: word still 66 bits, next word 8 bits
        send(2'b10, rnd132(), rnd132(), 66, 20, 2'b00);
        send(2'b00, rnd132(), rnd132(), 8, -1, 2'b00);
        idle(2);

        // random mix of lengths, idles and aborts
        for (int k = 0; k < 25; k++) begin
            logic [1:0] gs;
            int len;
            gs = 2'($urandom_range(0, 3));
            len = model_len(gs);
            if ($urandom_range(0, 4) == 0) begin
                send(gs, rnd132(), rnd132(), $urandom_range(1, len - 1), -1, 2'b00);
                idle($urandom_range(1, 3));
            end else begin
                send(gs, rnd132(), rnd132(), len, -1, 2'b00);
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            end
        end
        idle(3);

        for (int t = 0; t < 200 && sb.size() > 0; t++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d words pending want 0", sb.size());
        end
        @(posedge clk);
        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
